j1_io_fabric: RTL and testbench

//  Parametrised I/O interconnect between the J1 core I/O port and NUM_SLV peripherals.

---
 rtl/j1_io_fabric.sv | 142 ++++++++++++++
 tb/tb_j1_io_fabric.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/j1_io_fabric.sv
// I/O interconnect between the J1 core I/O port and NUM_SLV paged peripherals,
// with a built-in status page that counts and records accesses to unmapped pages.
module j1_io_fabric #(
    parameter int          NUM_SLV    = 8,
    parameter logic [7:0]  BASE_PAGE  = 8'h64,
    parameter logic [7:0]  STAT_PAGE  = 8'h7F,
    parameter logic [15:0] DEFAULT_RD = 16'h0666,
    parameter int          RD_REG     = 0
) (
    input  logic                    sys_clk_i,
    input  logic                    sys_rst_i,
    input  logic                    io_rd,
    input  logic                    io_wr,
    input  logic [15:0]             io_addr,
    input  logic [15:0]             io_dout,
    output logic [15:0]             io_din,
    output logic [NUM_SLV-1:0]      slv_cs,
    input  logic [16*NUM_SLV-1:0]   slv_dout,
    output logic                    irq_err
);

    logic [7:0]  page;
    logic        slv_hit;
    logic        stat_hit;
    logic        fault;
    logic        clr;
    logic [15:0] stat_rd;
    logic [15:0] rd_data;
    logic        unused_dout;

    logic        err_q, err_d;
    logic        ovf_q, ovf_d;
    logic [15:0] err_cnt_q, err_cnt_d;
    logic [15:0] last_addr_q, last_addr_d;
    logic [1:0]  last_type_q, last_type_d;

    assign page        = io_addr[15:8];
    assign unused_dout = ^io_dout[15:1];

    // Compare in int so a slave page never aliases by wrapping past 8'hFF.
    always_comb begin
        slv_cs = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            slv_cs[i] = (int'(page) == int'(BASE_PAGE) + i);
        end
    end

    assign slv_hit  = |slv_cs;
    assign stat_hit = (page == STAT_PAGE);
    assign fault    = (io_rd | io_wr) & ~slv_hit & ~stat_hit;
    assign clr      = io_wr & stat_hit & (io_addr[3:0] == 4'd0) & io_dout[0];

    always_comb begin
        case (io_addr[3:0])
            4'd0:    stat_rd = {14'b0, ovf_q, err_q};
            4'd1:    stat_rd = err_cnt_q;
            4'd2:    stat_rd = last_addr_q;
            4'd3:    stat_rd = {14'b0, last_type_q};
            4'd4:    stat_rd = {8'(NUM_SLV), BASE_PAGE};
            default: stat_rd = 16'h0000;
        endcase
    end

    always_comb begin
        rd_data = DEFAULT_RD;
        if (stat_hit) begin
            rd_data = stat_rd;
        end
        for (int i = 0; i < NUM_SLV; i++) begin
            if (slv_cs[i]) begin
                rd_data = slv_dout[16*i +: 16];
            end
        end
    end

    // Clear and fault target different pages, so they are mutually exclusive.
    always_comb begin
        err_d       = err_q;
        ovf_d       = ovf_q;
        err_cnt_d   = err_cnt_q;
        last_addr_d = last_addr_q;
        last_type_d = last_type_q;
        if (clr) begin
            err_d     = 1'b0;
            ovf_d     = 1'b0;
            err_cnt_d = 16'h0000;
        end else if (fault) begin
            err_d       = 1'b1;
            last_addr_d = io_addr;
            last_type_d = {io_wr, io_rd};
            if (err_cnt_q == 16'hFFFF) begin
                ovf_d = 1'b1;
            end else begin
                err_cnt_d = err_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            err_q       <= 1'b0;
            ovf_q       <= 1'b0;
            err_cnt_q   <= 16'h0000;
            last_addr_q <= 16'h0000;
            last_type_q <= 2'b00;
        end else begin
            err_q       <= err_d;
            ovf_q       <= ovf_d;
            err_cnt_q   <= err_cnt_d;
            last_addr_q <= last_addr_d;
            last_type_q <= last_type_d;
        end
    end

    assign irq_err = err_q;

    generate
        if (RD_REG != 0) begin : g_rd_reg
            logic [15:0] rd_q, rd_d;

            always_comb begin
                rd_d = rd_q;
                if (io_rd) begin
                    rd_d = rd_data;
                end
            end

            always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
                if (sys_rst_i) begin
                    rd_q <= 16'h0000;
                end else begin
                    rd_q <= rd_d;
                end
            end

            assign io_din = rd_q;
        end else begin : g_rd_comb
            assign io_din = rd_data;
        end
    endgenerate

endmodule

// File: tb/tb_j1_io_fabric.sv
// Bench for j1_io_fabric: a combinational-read and a registered-read instance share
// the CPU-side stimulus and are compared against a behavioural model of the status page.
module tb_j1_io_fabric;

    localparam int          NSLV = 8;
    localparam logic [7:0]  BASE = 8'h64;
    localparam logic [7:0]  STAT = 8'h7F;
    localparam logic [15:0] DFLT = 16'h0666;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 io_rd, io_wr;
    logic [15:0]          io_addr, io_dout;
    logic [15:0]          din0, din1;
    logic [NSLV-1:0]      cs0, cs1;
    logic [16*NSLV-1:0]   slv_dout;
    logic                 irq0, irq1;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    // Behavioural model state
    bit          m_err, m_ovf;
    int          m_cnt;
    logic [15:0] m_last_addr, m_rdreg;
    logic [1:0]  m_last_type;

    always #5 clk = ~clk;

    j1_io_fabric #(.NUM_SLV(NSLV), .BASE_PAGE(BASE), .STAT_PAGE(STAT), .DEFAULT_RD(DFLT), .RD_REG(0)) dut0 (
        .sys_clk_i(clk), .sys_rst_i(rst), .io_rd(io_rd), .io_wr(io_wr), .io_addr(io_addr),
        .io_dout(io_dout), .io_din(din0), .slv_cs(cs0), .slv_dout(slv_dout), .irq_err(irq0));

    j1_io_fabric #(.NUM_SLV(NSLV), .BASE_PAGE(BASE), .STAT_PAGE(STAT), .DEFAULT_RD(DFLT), .RD_REG(1)) dut1 (
        .sys_clk_i(clk), .sys_rst_i(rst), .io_rd(io_rd), .io_wr(io_wr), .io_addr(io_addr),
        .io_dout(io_dout), .io_din(din1), .slv_cs(cs1), .slv_dout(slv_dout), .irq_err(irq1));

    function automatic bit is_slave(logic [7:0] pg);
        return (int'(pg) >= int'(BASE)) && (int'(pg) < int'(BASE) + NSLV);
    endfunction

    function automatic logic [NSLV-1:0] exp_cs(logic [15:0] a);
        logic [NSLV-1:0] r = '0;
        if (is_slave(a[15:8])) r[int'(a[15:8]) - int'(BASE)] = 1'b1;
        return r;
    endfunction

    function automatic logic [15:0] exp_read(logic [15:0] a);
        if (is_slave(a[15:8])) return slv_dout[16*(int'(a[15:8]) - int'(BASE)) +: 16];
        if (a[15:8] == STAT) begin
            case (a[3:0])
                4'd0:    return {14'b0, m_ovf, m_err};
                4'd1:    return m_cnt[15:0];
                4'd2:    return m_last_addr;
                4'd3:    return {14'b0, m_last_type};
                4'd4:    return {8'(NSLV), BASE};
                default: return 16'h0000;
            endcase
        end
        return DFLT;
    endfunction

    function automatic logic [15:0] unmapped_addr();
        logic [15:0] a;
        do a = 16'($urandom); while (is_slave(a[15:8]) || a[15:8] == STAT);
        return a;
    endfunction

    task automatic model_reset();
        m_err = 0; m_ovf = 0; m_cnt = 0; m_last_addr = 0; m_last_type = 0; m_rdreg = 0;
    endtask

    task automatic drive(bit rd, bit wr, logic [15:0] a, logic [15:0] d);
        io_rd = rd; io_wr = wr; io_addr = a; io_dout = d;
        #1;
    endtask

    // Advance one clock edge and apply the access rules to the model.
    task automatic tick();
        logic [15:0] nxt;
        bit flt, clr;
        nxt = exp_read(io_addr);
        flt = (io_rd || io_wr) && !is_slave(io_addr[15:8]) && io_addr[15:8] != STAT;
        clr = io_wr && io_addr[15:8] == STAT && io_addr[3:0] == 4'd0 && io_dout[0];
        @(posedge clk);
        #1;
        if (io_rd) m_rdreg = nxt;
        if (clr) begin
            m_err = 0; m_ovf = 0; m_cnt = 0;
        end else if (flt) begin
            m_err = 1;
            if (m_cnt == 65535) m_ovf = 1; else m_cnt++;
            m_last_addr = io_addr;
            m_last_type = {io_wr, io_rd};
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        slv_dout = '0;
        drive(0, 0, {8'(BASE + 8'd2), 8'h00}, 16'h0);
        chk_cnt++; if (cs0 !== 8'b00000100) $display("FAIL reset_cs got %b want %b", cs0, 8'b00000100); else pass_cnt++;
        chk_cnt++; if (irq0 !== 1'b0) $display("FAIL reset_irq0 got %b want 0", irq0); else pass_cnt++;
        chk_cnt++; if (irq1 !== 1'b0) $display("FAIL reset_irq1 got %b want 0", irq1); else pass_cnt++;
        chk_cnt++; if (din1 !== 16'h0000) $display("FAIL reset_din1 got %h want 0000", din1); else pass_cnt++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int r = 0; r < 4; r++) begin
            drive(1, 0, {STAT, 8'(r)}, 16'h0);
            chk_cnt++; if (din0 !== 16'h0000) $display("FAIL reset_stat%0d got %h want 0000", r, din0); else pass_cnt++;
            tick();
        end
    endtask

    task automatic test_slave_read();
        slv_dout = '0;
        slv_dout[47:32] = 16'hBEEF;
        drive(1, 0, {8'(BASE + 8'd2), 8'h10}, 16'h0);
        chk_cnt++; if (cs0 !== 8'b00000100) $display("FAIL slv2_cs got %b want %b", cs0, 8'b00000100); else pass_cnt++;
        chk_cnt++; if (din0 !== 16'hBEEF) $display("FAIL slv2_din0 got %h want BEEF", din0); else pass_cnt++;
        tick();
        chk_cnt++; if (din1 !== 16'hBEEF) $display("FAIL slv2_din1 got %h want BEEF", din1); else pass_cnt++;
        for (int n = 0; n < 16; n++) begin
            int k;
            logic [15:0] a;
            k = $urandom_range(0, NSLV - 1);
            slv_dout = {$urandom, $urandom, $urandom, $urandom};
            a = {8'(int'(BASE) + k), 8'($urandom)};
            drive(1, 0, a, 16'($urandom));
            chk_cnt++; if (cs0 !== exp_cs(a)) $display("FAIL slv_cs a=%h got %b want %b", a, cs0, exp_cs(a)); else pass_cnt++;
            chk_cnt++; if (din0 !== exp_read(a)) $display("FAIL slv_din0 a=%h got %h want %h", a, din0, exp_read(a)); else pass_cnt++;
            tick();
            chk_cnt++; if (din1 !== m_rdreg) $display("FAIL slv_din1 a=%h got %h want %h", a, din1, m_rdreg); else pass_cnt++;
        end
    endtask

    task automatic test_unmapped();
        drive(1, 0, 16'h5000, 16'h0);
        chk_cnt++; if (din0 !== 16'h0666) $display("FAIL unm_din got %h want 0666", din0); else pass_cnt++;
        chk_cnt++; if (cs0 !== '0) $display("FAIL unm_cs got %b want 0", cs0); else pass_cnt++;
        tick();
        chk_cnt++; if (irq0 !== 1'b1) $display("FAIL unm_irq got %b want 1", irq0); else pass_cnt++;
        drive(1, 0, {STAT, 8'h00}, 16'h0);
        chk_cnt++; if (din0 !== 16'h0001) $display("FAIL unm_status got %h want 0001", din0); else pass_cnt++;
        tick();
        drive(1, 0, {STAT, 8'h01}, 16'h0);
        chk_cnt++; if (din0 !== 16'h0001) $display("FAIL unm_errcnt got %h want 0001", din0); else pass_cnt++;
        tick();
        drive(1, 0, {STAT, 8'h02}, 16'h0);
        chk_cnt++; if (din0 !== 16'h5000) $display("FAIL unm_lastaddr got %h want 5000", din0); else pass_cnt++;
        tick();
        drive(1, 0, {STAT, 8'h03}, 16'h0);
        chk_cnt++; if (din0 !== 16'h0001) $display("FAIL unm_lasttype got %h want 0001", din0); else pass_cnt++;
        tick();
    endtask

    task automatic test_clear();
        logic [15:0] last;
        for (int n = 0; n < 3; n++) begin
            int t;
            last = unmapped_addr();
            t = $urandom_range(1, 3);
            drive(t[0], t[1], last, 16'($urandom));
            tick();
        end
        drive(1, 0, {STAT, 8'h01}, 16'h0);
        chk_cnt++; if (din0 !== 16'h0004) $display("FAIL clr_pre_cnt got %h want 0004", din0); else pass_cnt++;
        tick();
        drive(0, 1, {STAT, 8'h00}, 16'h0001);
        tick();
        chk_cnt++; if (irq0 !== 1'b0) $display("FAIL clr_irq got %b want 0", irq0); else pass_cnt++;
        drive(1, 0, {STAT, 8'h00}, 16'h0);
        chk_cnt++; if (din0 !== 16'h0000) $display("FAIL clr_status got %h want 0000", din0); else pass_cnt++;
        tick();
        drive(1, 0, {STAT, 8'h01}, 16'h0);
        chk_cnt++; if (din0 !== 16'h0000) $display("FAIL clr_cnt got %h want 0000", din0); else pass_cnt++;
        tick();
        drive(1, 0, {STAT, 8'h02}, 16'h0);
        chk_cnt++; if (din0 !== last) $display("FAIL clr_lastaddr got %h want %h", din0, last); else pass_cnt++;
        tick();
    endtask

    task automatic test_id();
        drive(1, 0, {STAT, 8'h04}, 16'h0);
        chk_cnt++; if (din0 !== 16'h0864) $display("FAIL id_read got %h want 0864", din0); else pass_cnt++;
        tick();
        drive(0, 1, {STAT, 8'h04}, 16'h1234);
        tick();
        chk_cnt++; if (irq0 !== 1'b0) $display("FAIL id_wr_irq got %b want 0", irq0); else pass_cnt++;
        drive(1, 0, {STAT, 8'h04}, 16'h0);
        chk_cnt++; if (din0 !== 16'h0864) $display("FAIL id_after_wr got %h want 0864", din0); else pass_cnt++;
        tick();
        drive(1, 0, {STAT, 8'h01}, 16'h0);
        chk_cnt++; if (din0 !== 16'h0000) $display("FAIL id_wr_cnt got %h want 0000", din0); else pass_cnt++;
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            logic [15:0] a;
            case ($urandom_range(0, 3))
                0:       a = {8'(int'(BASE) + int'($urandom_range(0, NSLV - 1))), 8'($urandom)};
                1:       a = {STAT, 4'($urandom), 4'($urandom_range(0, 7))};
                2:       a = unmapped_addr();
                default: a = 16'($urandom);
            endcase
            slv_dout = {$urandom, $urandom, $urandom, $urandom};
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, 16'($urandom));
            chk_cnt++; if (cs0 !== exp_cs(a)) $display("FAIL rnd_cs a=%h got %b want %b", a, cs0, exp_cs(a)); else pass_cnt++;
            chk_cnt++; if (din0 !== exp_read(a)) $display("FAIL rnd_din0 a=%h got %h want %h", a, din0, exp_read(a)); else pass_cnt++;
            chk_cnt++; if (irq0 !== m_err) $display("FAIL rnd_irq0 got %b want %b", irq0, m_err); else pass_cnt++;
            tick();
            chk_cnt++; if (din1 !== m_rdreg) $display("FAIL rnd_din1 a=%h got %h want %h", a, din1, m_rdreg); else pass_cnt++;
            chk_cnt++; if (irq1 !== m_err) $display("FAIL rnd_irq1 got %b want %b", irq1, m_err); else pass_cnt++;
        end
    endtask

    task automatic test_saturate();
        drive(0, 1, {STAT, 8'h00}, 16'h0001);
        tick();
        drive(1, 0, 16'h5000, 16'h0);
        for (int n = 0; n < 65534; n++) tick();
        drive(1, 0, {STAT, 8'h01}, 16'h0);
        chk_cnt++; if (din0 !== 16'hFFFE) $display("FAIL sat_fffe got %h want FFFE", din0); else pass_cnt++;
        tick();
        drive(0, 1, 16'h5001, 16'h0);
        tick();
        drive(1, 0, {STAT, 8'h01}, 16'h0);
        chk_cnt++; if (din0 !== 16'hFFFF) $display("FAIL sat_ffff got %h want FFFF", din0); else pass_cnt++;
        tick();
        drive(1, 0, {STAT, 8'h00}, 16'h0);
        chk_cnt++; if (din0 !== 16'h0001) $display("FAIL sat_no_ovf got %h want 0001", din0); else pass_cnt++;
        tick();
        drive(1, 1, 16'h5002, 16'h0);
        tick();
        drive(1, 0, {STAT, 8'h01}, 16'h0);
        chk_cnt++; if (din0 !== 16'hFFFF) $display("FAIL sat_held got %h want FFFF", din0); else pass_cnt++;
        tick();
        drive(1, 0, {STAT, 8'h00}, 16'h0);
        chk_cnt++; if (din0 !== 16'h0003) $display("FAIL sat_ovf got %h want 0003", din0); else pass_cnt++;
        tick();
        drive(1, 0, {STAT, 8'h03}, 16'h0);
        chk_cnt++; if (din0 !== 16'h0003) $display("FAIL sat_type got %h want 0003", din0); else pass_cnt++;
        tick();
    endtask

    task automatic test_async_reset();
        slv_dout = {$urandom, $urandom, $urandom, $urandom};
        slv_dout[31:16] = 16'hA5A5;
        drive(1, 0, {8'(BASE + 8'd1), 8'h00}, 16'h0);
        tick();
        chk_cnt++; if (din1 !== 16'hA5A5) $display("FAIL ar_pre_din1 got %h want A5A5", din1); else pass_cnt++;
        drive(1, 0, {STAT, 8'h01}, 16'h0);
        #2;
        rst = 1'b1;
        #1;
        chk_cnt++; if (din1 !== 16'h0000) $display("FAIL ar_din1 got %h want 0000", din1); else pass_cnt++;
        chk_cnt++; if (din0 !== 16'h0000) $display("FAIL ar_errcnt got %h want 0000", din0); else pass_cnt++;
        chk_cnt++; if (irq0 !== 1'b0) $display("FAIL ar_irq0 got %b want 0", irq0); else pass_cnt++;
        chk_cnt++; if (irq1 !== 1'b0) $display("FAIL ar_irq1 got %b want 0", irq1); else pass_cnt++;
        drive(1, 0, {8'(BASE + 8'd3), 8'h00}, 16'h0);
        chk_cnt++; if (cs0 !== 8'b00001000) $display("FAIL ar_cs got %b want %b", cs0, 8'b00001000); else pass_cnt++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        drive(0, 0, 16'h0000, 16'h0);
        tick();
    endtask

    initial begin
        io_rd = 0; io_wr = 0; io_addr = 0; io_dout = 0; rst = 1'b1;
        slv_dout = '0;
        model_reset();
        test_reset();
        test_slave_read();
        test_unmapped();
        test_clear();
        test_id();
        test_random();
        test_saturate();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
